// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline hazard controller. It drives the stall and flush controls for the
// IF/ID and ID/EX registers and the EX-stage operand forwarding selects. A
// memory-wait FSM freezes the whole pipe while the data memory is slow, and a
// watchdog flags a wait that runs too long.
//
// Handshake: the memory stage presents an access with mem_req_M. The access
// completes in the cycle where mem_ready_M is 1. While mem_req_M=1 and
// mem_ready_M=0 the access is pending, and every pipeline register is held.
//
// Optional feature: define HAZARD_PERF_EN to add three free-running 32-bit
// performance counters (stall_cnt_o, flush_cnt_o, wait_cnt_o).
//
// Parameters
//   WB_LOAD   wb_sel_E code that marks a load in Execute
//   TIMEOUT   ready-low cycles (>=1) in one wait before o_mem_timeout sets
//   CNT_W     wait counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   i_clk, i_rst_n               clock, async active-low reset
//   rs1_addr_D, rs2_addr_D       Decode source addresses
//   rs1_addr_E, rs2_addr_E       Execute source addresses
//   rd_addr_E, rd_wren_E         Execute destination and write enable
//   wb_sel_E                     Execute write-back select
//   rd_addr_M, rd_wren_M         Memory-stage destination and write enable
//   rd_addr_W, rd_wren_W         Write-back destination and write enable
//   br_taken_E                   branch/jump taken in Execute
//   mem_req_M, mem_ready_M       dmem access request / completion
//   StallF, StallD, StallE, StallM   hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE               bubble IF/ID, ID/EX
//   fwd_a_E, fwd_b_E             00 reg file, 01 WB result, 10 MEM result
//   o_mem_timeout                sticky dmem-wait watchdog flag
//   dbg_state                    1 while the FSM is in MEMWAIT
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter logic [1:0] WB_LOAD = 2'b01,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  rs1_addr_D,
  input  logic [4:0]  rs2_addr_D,
  input  logic [4:0]  rs1_addr_E,
  input  logic [4:0]  rs2_addr_E,
  input  logic [4:0]  rd_addr_E,
  input  logic        rd_wren_E,
  input  logic [1:0]  wb_sel_E,
  input  logic [4:0]  rd_addr_M,
  input  logic        rd_wren_M,
  input  logic [4:0]  rd_addr_W,
  input  logic        rd_wren_W,
  input  logic        br_taken_E,
  input  logic        mem_req_M,
  input  logic        mem_ready_M,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  fwd_a_E,
  output logic [1:0]  fwd_b_E,
  output logic        o_mem_timeout,
  output logic        dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             lu;
  logic             mem_pend;

  // Forwarding select for one operand. The MEM stage holds the younger value,
  // so it wins over WB. Register x0 is hard-wired and is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rd_wren_M && (rd_addr_M != 5'd0) && (rd_addr_M == rs))
      return 2'b10;
    else if (rd_wren_W && (rd_addr_W != 5'd0) && (rd_addr_W == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Load in Execute whose result a Decode source needs.
  assign lu = rd_wren_E && (wb_sel_E == WB_LOAD) && (rd_addr_E != 5'd0) &&
              ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

  assign mem_pend = mem_req_M && !mem_ready_M;

  // The counter saturates so a very long wait cannot wrap and hide the timeout.
  assign cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_ONE;

  assign dbg_state = (state == MEMWAIT);

  // Stall, flush and forwarding controls. All are same-cycle functions of the
  // inputs and the current state. They are held at 0 while reset is asserted.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (i_rst_n) begin
      fwd_a_E = fwd_sel(rs1_addr_E);
      fwd_b_E = fwd_sel(rs2_addr_E);
      // In RUN a fresh pending access freezes the pipe. In MEMWAIT the pipe
      // stays frozen until ready. Branch and load-use are deferred until then.
      if ((state == RUN && mem_pend) || (state == MEMWAIT && !mem_ready_M)) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (br_taken_E) begin
        // The flush squashes any load-use victim sitting in Decode.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu) begin
        // One bubble. Next cycle the load has moved to M and lu drops.
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_pend) begin
            state    <= MEMWAIT;
            wait_cnt <= CNT_ONE;
            if (CNT_ONE >= TIMEOUT_C) o_mem_timeout <= 1'b1;
          end
        end
        MEMWAIT: begin
          if (mem_ready_M) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            // No forced release. The flag records the overrun and the pipe keeps waiting.
            wait_cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT_C) o_mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      wait_cnt_o  <= '0;
    end else begin
      if (StallD)             stall_cnt_o <= stall_cnt_o + 32'd1;
      if (FlushE)             flush_cnt_o <= flush_cnt_o + 32'd1;
      if (state == MEMWAIT)   wait_cnt_o  <= wait_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed vectors for hazard_ctrl_unit, built with TIMEOUT=4. The driver
// applies one vector just after each rising edge and queues its hand-computed
// response. The monitor pops and compares that response on the following
// falling edge.
//
// Response word: {StallF,StallD,StallE,StallM,FlushD,FlushE,
//                 fwd_a_E[1:0],fwd_b_E[1:0],o_mem_timeout,dbg_state}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  localparam int W = 12;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [4:0] rd_addr_E, rd_addr_M, rd_addr_W;
  logic       rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0] wb_sel_E;
  logic       br_taken_E, mem_req_M, mem_ready_M;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       o_mem_timeout, dbg_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;
`endif

  hazard_ctrl_unit #(.WB_LOAD(2'b01), .TIMEOUT(4), .CNT_W(7)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E), .wb_sel_E(wb_sel_E),
    .rd_addr_M(rd_addr_M), .rd_wren_M(rd_wren_M),
    .rd_addr_W(rd_addr_W), .rd_wren_W(rd_wren_W),
    .br_taken_E(br_taken_E), .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .o_mem_timeout(o_mem_timeout), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .wait_cnt_o(wait_cnt_o)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_bad = 0;

  function automatic logic [W-1:0] mk(input logic sf, input logic sd, input logic se,
                                      input logic sm, input logic fd, input logic fe,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic to, input logic st);
    return {sf, sd, se, sm, fd, fe, fa, fb, to, st};
  endfunction

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {StallF, StallD, StallE, StallM, FlushD, FlushE,
            fwd_a_E, fwd_b_E, o_mem_timeout, dbg_state};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %b required %b (SF SD SE SM FD FE fa fb to st)", nm, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
    rd_addr_E  = 5'd0; rd_addr_M  = 5'd0; rd_addr_W  = 5'd0;
    rd_wren_E  = 1'b0; rd_wren_M  = 1'b0; rd_wren_W  = 1'b0;
    wb_sel_E   = 2'b00; br_taken_E = 1'b0; mem_req_M = 1'b0; mem_ready_M = 1'b0;
  endtask

  // Queue the response for the inputs already applied. Then advance to just
  // after the next rising edge.
  task automatic cyc(input logic [W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_load_use();
    rd_wren_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd5; rs1_addr_D = 5'd5;
  endtask

  logic [W-1:0] ZERO, STALL_RUN, STALL_WAIT, STALL_WAIT_TO;

  initial begin
    ZERO          = mk(0,0,0,0,0,0,2'b00,2'b00,0,0);
    STALL_RUN     = mk(1,1,1,1,0,0,2'b00,2'b00,0,0);
    STALL_WAIT    = mk(1,1,1,1,0,0,2'b00,2'b00,0,1);
    STALL_WAIT_TO = mk(1,1,1,1,0,0,2'b00,2'b00,1,1);

    // Reset held: provoke every hazard source. All outputs must stay 0.
    clr_in();
    set_load_use();
    br_taken_E = 1'b1; mem_req_M = 1'b1;
    rd_wren_M = 1'b1; rd_addr_M = 5'd3; rs1_addr_E = 5'd3;
    @(posedge i_clk); #1;
    cyc(ZERO, "reset_held_a");
    cyc(ZERO, "reset_held_b");
    i_rst_n = 1'b1;
    clr_in();
    cyc(ZERO, "after_reset_idle");

    // Load-use: one bubble, then clear once the load has moved on.
    set_load_use();
    cyc(mk(1,1,0,0,0,1,2'b00,2'b00,0,0), "load_use_rs1");
    clr_in(); rd_wren_M = 1'b1; rd_addr_M = 5'd5;
    cyc(ZERO, "load_use_cleared");
    clr_in(); rd_wren_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd5;
    rs1_addr_D = 5'd1; rs2_addr_D = 5'd5;
    cyc(mk(1,1,0,0,0,1,2'b00,2'b00,0,0), "load_use_rs2");
    clr_in(); rd_wren_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd0;
    cyc(ZERO, "load_use_x0");
    clr_in(); rd_wren_E = 1'b1; wb_sel_E = 2'b00; rd_addr_E = 5'd5; rs1_addr_D = 5'd5;
    cyc(ZERO, "alu_not_load");
    clr_in(); rd_wren_E = 1'b0; wb_sel_E = 2'b01; rd_addr_E = 5'd5; rs1_addr_D = 5'd5;
    cyc(ZERO, "load_no_wren");

    // Forwarding.
    clr_in(); rd_addr_M = 5'd7; rd_addr_W = 5'd7; rd_wren_M = 1'b1; rd_wren_W = 1'b1;
    rs2_addr_E = 5'd7; rs1_addr_E = 5'd2;
    cyc(mk(0,0,0,0,0,0,2'b00,2'b10,0,0), "fwd_b_mem_beats_wb");
    rd_wren_M = 1'b0;
    cyc(mk(0,0,0,0,0,0,2'b00,2'b01,0,0), "fwd_b_wb");
    clr_in(); rd_addr_W = 5'd9; rd_wren_W = 1'b1; rs1_addr_E = 5'd9;
    rd_addr_M = 5'd4; rd_wren_M = 1'b1; rs2_addr_E = 5'd4;
    cyc(mk(0,0,0,0,0,0,2'b01,2'b10,0,0), "fwd_a_wb_b_mem");
    clr_in(); rd_addr_M = 5'd0; rd_wren_M = 1'b1; rd_addr_W = 5'd0; rd_wren_W = 1'b1;
    cyc(ZERO, "fwd_x0_never");

    // Branch beats load-use.
    clr_in(); set_load_use(); br_taken_E = 1'b1;
    cyc(mk(0,0,0,0,1,1,2'b00,2'b00,0,0), "branch_over_load_use");

    // Memory wait with ready low for 3 cycles. Branch and load-use are deferred.
    clr_in(); mem_req_M = 1'b1;
    cyc(STALL_RUN, "memwait_c1");
    set_load_use();
    cyc(STALL_WAIT, "memwait_c2_lu_deferred");
    br_taken_E = 1'b1;
    cyc(STALL_WAIT, "memwait_c3_br_deferred");
    mem_ready_M = 1'b1;
    cyc(mk(0,0,0,0,1,1,2'b00,2'b00,0,1), "memwait_release_br");
    clr_in();
    cyc(ZERO, "back_in_run");

    // Forwarding stays live while the pipe is frozen.
    mem_req_M = 1'b1; rd_wren_M = 1'b1; rd_addr_M = 5'd6; rs1_addr_E = 5'd6;
    cyc(mk(1,1,1,1,0,0,2'b10,2'b00,0,0), "wait_fwd_c1");
    mem_ready_M = 1'b1; set_load_use();
    cyc(mk(1,1,0,0,0,1,2'b10,2'b00,0,1), "wait_release_lu");
    // Back-to-back access: the counter restarts, so the timeout rises after 4 ready-low cycles.
    clr_in(); mem_req_M = 1'b1;
    cyc(STALL_RUN, "to_c1");
    cyc(STALL_WAIT, "to_c2");
    cyc(STALL_WAIT, "to_c3");
    cyc(STALL_WAIT, "to_c4");
    for (int i = 5; i <= 10; i++) cyc(STALL_WAIT_TO, $sformatf("to_sticky_c%0d", i));
    mem_ready_M = 1'b1;
    cyc(mk(0,0,0,0,0,0,2'b00,2'b00,1,1), "to_release");
    clr_in();
    cyc(mk(0,0,0,0,0,0,2'b00,2'b00,1,0), "to_sticky_run");

    // Reset in the middle of a wait aborts the wait and clears the flag.
    mem_req_M = 1'b1;
    cyc(mk(1,1,1,1,0,0,2'b00,2'b00,1,0), "pre_reset_c1");
    cyc(STALL_WAIT_TO, "pre_reset_c2");
    i_rst_n = 1'b0;
    cyc(ZERO, "reset_mid_wait");
    i_rst_n = 1'b1; mem_req_M = 1'b0;
    cyc(ZERO, "after_reset_run");
    mem_req_M = 1'b1;
    cyc(STALL_RUN, "post_reset_wait_c1");
    mem_ready_M = 1'b1;
    cyc(mk(0,0,0,0,0,0,2'b00,2'b00,0,1), "post_reset_release");
    clr_in();
    cyc(ZERO, "final_idle");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge i_clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d responses left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
